// File: rtl/vc_allocator.sv
// Virtual-channel allocator: a round-robin requester arbiter per output port.
// The winner on each port gets that port's lowest-index free downstream VC.
module vc_alloc_port #(
  parameter int VC_TOTAL = 10,
  parameter int VC_NUM   = 2,
  parameter int PTR_W    = 4,
  parameter int VC_SIZE  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VC_TOTAL-1:0] match_i,
  input  logic [VC_NUM-1:0]   free_i,
  output logic [VC_TOTAL-1:0] gnt_o,
  output logic [VC_SIZE-1:0]  vc_o
);
  logic [VC_NUM-1:0]  busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               vc_avail, win_vld, grant;
  logic [VC_SIZE-1:0] vc_sel;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     sum;

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    vc_avail = 1'b0;
    vc_sel   = '0;
    for (int v = VC_NUM-1; v >= 0; v--) begin
      if (!busy_q[v]) begin
        vc_avail = 1'b1;
        vc_sel   = VC_SIZE'(v);
      end
    end
  end

  // Scan offsets downward so the match nearest the pointer is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    for (int off = VC_TOTAL-1; off >= 0; off--) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(VC_TOTAL)) sum = sum - (PTR_W+1)'(VC_TOTAL);
      if (match_i[sum[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant = win_vld & vc_avail & rst;
    gnt_o = '0;
    if (grant) gnt_o[win_idx] = 1'b1;
    vc_o  = grant ? vc_sel : '0;
  end

  // A VC freed this cycle is still busy for this cycle's allocation.
  always_comb begin
    busy_d = busy_q & ~free_i;
    ptr_d  = ptr_q;
    if (grant) begin
      busy_d[vc_sel] = 1'b1;
      ptr_d = (win_idx == PTR_W'(VC_TOTAL-1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      ptr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end
endmodule

module vc_allocator #(
  parameter  int VC_TOTAL  = 10,
  parameter  int PORT_NUM  = 5,
  parameter  int VC_NUM    = 2,
  localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int PTR_W     = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                free_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]                grant_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   vc_new_o
);
  logic [VC_TOTAL-1:0]                 req_flat, grant_flat;
  logic [VC_TOTAL-1:0][PORT_SIZE-1:0]  op_flat;
  logic [VC_TOTAL-1:0][VC_SIZE-1:0]    vc_flat;
  logic [PORT_NUM-1:0][VC_TOTAL-1:0]   match, gnt;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]    port_vc;

  assign req_flat = request_i;
  assign op_flat  = out_port_i;

  // Out-of-range ports never equal any port index, so they drop out here.
  always_comb begin
    match = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int i = 0; i < VC_TOTAL; i++)
        match[p][i] = req_flat[i] && (op_flat[i] == PORT_SIZE'(p));
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    vc_alloc_port #(
      .VC_TOTAL (VC_TOTAL),
      .VC_NUM   (VC_NUM),
      .PTR_W    (PTR_W),
      .VC_SIZE  (VC_SIZE)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .match_i (match[p]),
      .free_i  (free_i[p]),
      .gnt_o   (gnt[p]),
      .vc_o    (port_vc[p])
    );
  end

  // Each requester targets one port, so at most one port grants it.
  always_comb begin
    grant_flat = '0;
    vc_flat    = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      grant_flat = grant_flat | gnt[p];
      for (int i = 0; i < VC_TOTAL; i++)
        if (gnt[p][i]) vc_flat[i] = port_vc[p];
    end
  end

  assign grant_o  = grant_flat;
  assign vc_new_o = vc_flat;
endmodule

// File: tb/tb_vc_allocator.sv
// Bench for vc_allocator: vector table through a scoreboard queue plus reset sequences.
module tb_vc_allocator;
  localparam int VT = 10, PN = 5, VN = 2;

  logic clk, rst;
  logic [PN-1:0][VN-1:0]        request_i, free_i, grant_o;
  logic [PN-1:0][VN-1:0][2:0]   out_port_i;
  logic [PN-1:0][VN-1:0][0:0]   vc_new_o;

  vc_allocator #(.VC_TOTAL(VT), .PORT_NUM(PN), .VC_NUM(VN)) dut (
    .clk(clk), .rst(rst), .request_i(request_i), .out_port_i(out_port_i),
    .free_i(free_i), .grant_o(grant_o), .vc_new_o(vc_new_o)
  );

  // op: nibble i holds the output port of requester i
  typedef struct {
    logic [9:0]  req;
    logic [39:0] op;
    logic [9:0]  fr;
    logic [9:0]  eg;
    logic [9:0]  ev;
    string       name;
  } vec_t;
  typedef struct { logic [9:0] eg; logic [9:0] ev; string name; } exp_t;

  exp_t sb[$];
  vec_t vt[20];
  vec_t rv[2];
  int n_tests = 0, n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [9:0] b(int i);
    return 10'(1) << i;
  endfunction

  task automatic drive(input logic [9:0] req, input logic [39:0] op, input logic [9:0] fr);
    request_i = req;
    free_i    = fr;
    for (int i = 0; i < VT; i++) out_port_i[i/VN][i%VN] = op[i*4 +: 3];
  endtask

  task automatic check(input string name, input logic [9:0] eg, input logic [9:0] ev);
    n_tests++;
    if (grant_o !== eg || vc_new_o !== ev) begin
      n_fail++;
      $display("FAIL %s: grant=%b vc=%b expected grant=%b vc=%b", name, grant_o, vc_new_o, eg, ev);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    drive(v.req, v.op, v.fr);
    sb.push_back('{eg: v.eg, ev: v.ev, name: v.name});
    @(negedge clk);
    e = sb.pop_front();
    check(e.name, e.eg, e.ev);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{10'b0,          40'h0,          10'b0,       10'b0,          10'b0, "idle"};
    vt[1]  = '{b(2),           40'h0000000300, 10'b0,       b(2),           10'b0, "first_grant_vc0"};
    vt[2]  = '{b(2),           40'h0000000300, 10'b0,       b(2),           b(2),  "vc0_busy_gets_vc1"};
    vt[3]  = '{b(2),           40'h0000000300, 10'b0,       10'b0,          10'b0, "port3_full"};
    vt[4]  = '{b(2),           40'h0000000300, b(6),        10'b0,          10'b0, "free_not_same_cycle"};
    vt[5]  = '{b(2),           40'h0000000300, 10'b0,       b(2),           10'b0, "freed_vc0_reused"};
    vt[6]  = '{b(0)|b(5)|b(8), 40'h0200200002, 10'b0,       b(0),           10'b0, "p2_rr_first"};
    vt[7]  = '{b(5)|b(8),      40'h0200200002, 10'b0,       b(5),           b(5),  "p2_rr_second"};
    vt[8]  = '{b(8),           40'h0200200002, 10'b0,       10'b0,          10'b0, "p2_full_pending"};
    vt[9]  = '{b(8),           40'h0200200002, b(5),        10'b0,          10'b0, "p2_free_cycle_n"};
    vt[10] = '{b(8),           40'h0200200002, 10'b0,       b(8),           b(8),  "p2_grant_cycle_n1"};
    vt[11] = '{b(3)|b(4),      40'h0000041000, 10'b0,       b(3)|b(4),      10'b0, "two_ports_same_cycle"};
    vt[12] = '{b(1)|b(7),      40'h0070000050, 10'b0,       10'b0,          10'b0, "bad_port_ignored"};
    vt[13] = '{b(1),           40'h0,          10'b0,       b(1),           10'b0, "p0_untouched_by_bad"};
    vt[14] = '{b(8),           40'h0,          10'b0,       b(8),           b(8),  "p0_ptr_to_9"};
    vt[15] = '{10'b0,          40'h0,          b(0)|b(1),   10'b0,          10'b0, "p0_free_both"};
    vt[16] = '{b(9)|b(0),      40'h0,          10'b0,       b(9),           10'b0, "ptr9_idx9_wins"};
    vt[17] = '{b(9)|b(0),      40'h0,          10'b0,       b(0),           b(0),  "ptr_wrap_idx0_wins"};
    vt[18] = '{b(3),           40'h0000004000, b(9),        b(3),           b(3),  "free_nonbusy_ignored"};
    vt[19] = '{b(3),           40'h0000004000, 10'b0,       10'b0,          10'b0, "port4_full"};
    rv[0]  = '{b(0)|b(9)|b(3)|b(4)|b(6)|b(7), 40'h0043021000, 10'b0,
               b(0)|b(3)|b(4)|b(6)|b(7), 10'b0, "post_rst_all_free"};
    rv[1]  = '{b(9),           40'h0,          10'b0,       b(9),           b(9),  "post_rst_ptr0"};

    // requests presented while in reset must not grant
    rst = 1'b0;
    drive(b(2), 40'h0000000300, 10'b0);
    #3;
    check("reset_forces_zero", 10'b0, 10'b0);
    @(posedge clk); #1;
    check("reset_across_edge", 10'b0, 10'b0);
    drive(10'b0, 40'h0, 10'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 20; k++) step(vt[k]);

    // mid-operation reset with most downstream VCs busy
    drive(b(0), 40'h0000000001, 10'b0);
    #1;
    check("pre_rst_grant", b(0), b(0));
    #2 rst = 1'b0;
    #1;
    check("rst_async_drop", 10'b0, 10'b0);
    @(posedge clk); #1;
    check("rst_held_edge", 10'b0, 10'b0);
    drive(10'b0, 40'h0, 10'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) step(rv[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vc_allocator.md
VC_ALLOCATOR -- requirements
Module: vc_allocator

Interface
REQ-001 SHALL have parameter VC_TOTAL, default 10, total input VCs (PORT_NUM*VC_NUM).
REQ-002 SHALL have parameter PORT_NUM, default 5, number of router ports.
REQ-003 SHALL have parameter VC_NUM, default 2, number of VCs per port.
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port request_i  input  [PORT_NUM][VC_NUM]  head flit at input VC needs a downstream VC.
REQ-007 SHALL have port out_port_i  input  [PORT_NUM][VC_NUM] x PORT_SIZE  routed output port of each requesting VC.
REQ-008 SHALL have port free_i  input  [PORT_NUM][VC_NUM]  one-cycle pulse: downstream VC [out][dvc] released (tail flit departed).
REQ-009 SHALL have port grant_o  output  [PORT_NUM][VC_NUM]  input VC was allocated a downstream VC this cycle.
REQ-010 SHALL have port vc_new_o  output  [PORT_NUM][VC_NUM] x VC_SIZE  allocated downstream VC index, valid only with grant_o.

Function
REQ-011 SHALL hold one busy bit per downstream VC (PORT_NUM x VC_NUM) and one round-robin pointer per output port (range 0..VC_TOTAL-1).
REQ-012 SHALL flatten requester index as port*VC_NUM+vc.
REQ-013 SHALL, per output port, choose at most one winner per cycle among requesters with request_i=1 and out_port_i equal to that port.
REQ-014 SHALL search requesters starting at the pointer, ascending, wrapping VC_TOTAL-1 -> 0; first match wins.
REQ-015 SHALL grant only if the output port has at least one non-busy downstream VC; the lowest-index non-busy VC is assigned.
REQ-016 SHALL drive grant_o and vc_new_o combinationally from registered state and current inputs (zero-cycle latency).
REQ-017 SHALL drive vc_new_o to 0 for every requester without grant.
REQ-018 SHALL, on a grant at the clock edge, set the assigned VC busy and load the pointer with winner+1 mod VC_TOTAL.
REQ-019 SHALL leave the pointer unchanged on any cycle without a grant for that port.
REQ-020 SHALL clear the busy bit at the edge following a free_i pulse; a freed VC is allocatable from the next cycle, not the same cycle.
REQ-021 SHALL ignore free_i on a non-busy VC.
REQ-022 SHALL ignore requests whose out_port_i >= PORT_NUM (no grant, no state change).
REQ-023 SHALL grant each input VC at most once per cycle; requester drops request_i after grant, and a request held after grant is treated as new.
REQ-024 SHALL allow simultaneous grants on different output ports in the same cycle.
REQ-025 SHALL, with all downstream VCs of a port busy, hold all its requests pending with no grant and no pointer change.

Reset
REQ-026 SHALL, while rst=0, clear all busy bits, set all pointers to 0, and force grant_o=0 and vc_new_o=0, independent of clk.
REQ-027 SHALL discard any allocation in progress when reset is asserted mid-operation; after release all downstream VCs are free.
REQ-028 SHALL take its first grant on the first rising edge after rst returns to 1.

Verification
REQ-029 SHALL pass: after reset, request_i[1][0]=1, out_port_i=3 -> same cycle grant_o[1][0]=1, vc_new_o[1][0]=0; next cycle downstream VC [3][0] busy.
REQ-030 SHALL pass: requests [0][0],[2][1],[4][0] all to port 2, held -> grants cycle 1 to [0][0] (VC0), cycle 2 to [2][1] (VC1), cycle 3 none (port full).
REQ-031 SHALL pass: port 2 full with [4][0] pending, free_i[2][1] pulsed cycle N -> no grant cycle N, grant_o[4][0]=1 with vc_new_o=1 cycle N+1.
REQ-032 SHALL pass: pointer of port 0 at 9, requests from indices 9 and 0 -> index 9 wins, pointer wraps to 0, index 0 wins next cycle.
REQ-033 SHALL pass: requests to ports 1 and 4 same cycle -> both granted same cycle, vc_new_o=0 each.
REQ-034 SHALL pass: rst asserted mid-cycle with several busy VCs -> grant_o drops immediately; after release all VCs free and pointers 0.
